// File: rtl/vga_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vga_pkg : shared VGA types and frame geometry
// rev 1.0 : initial release
// ----------------------------------------------------------------------------
package vga_pkg;

  localparam int VGA_MAX_H = 1280;
  localparam int VGA_MAX_V = 1024;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } vga_fill_state_e;

  typedef enum logic [1:0] {
    BLACK = 2'd0,
    WHITE = 2'd1,
    BLUE  = 2'd2,
    GREEN = 2'd3
  } vga_color_e;

endpackage
`default_nettype wire

// File: rtl/vga_rect_fill_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vga_rect_fill_if : command, pixel-write and status signals of vga_rect_fill
// rev 1.0 : initial release
// ----------------------------------------------------------------------------
interface vga_rect_fill_if #(
  parameter int X_WIDTH     = 11,
  parameter int Y_WIDTH     = 11,
  parameter int COLOR_WIDTH = 2
);

  logic                       cmd_valid_i;
  logic                       cmd_ready_o;
  logic [X_WIDTH-1:0]         cmd_x0_i;
  logic [X_WIDTH-1:0]         cmd_x1_i;
  logic [Y_WIDTH-1:0]         cmd_y0_i;
  logic [Y_WIDTH-1:0]         cmd_y1_i;
  logic [COLOR_WIDTH-1:0]     cmd_color_i;
  logic                       abort_i;
  logic                       we_o;
  logic [X_WIDTH-1:0]         addr_x_o;
  logic [Y_WIDTH-1:0]         addr_y_o;
  logic [COLOR_WIDTH-1:0]     color_o;
  logic                       wr_gnt_i;
  logic                       busy_o;
  logic                       done_o;
  logic                       err_o;
  logic                       aborted_o;
  logic [X_WIDTH+Y_WIDTH-1:0] pix_cnt_o;

  // slave = the fill engine, master = command source / frame buffer side
  modport slave (
    input  cmd_valid_i, cmd_x0_i, cmd_x1_i, cmd_y0_i, cmd_y1_i, cmd_color_i,
           abort_i, wr_gnt_i,
    output cmd_ready_o, we_o, addr_x_o, addr_y_o, color_o, busy_o, done_o,
           err_o, aborted_o, pix_cnt_o
  );

  modport master (
    output cmd_valid_i, cmd_x0_i, cmd_x1_i, cmd_y0_i, cmd_y1_i, cmd_color_i,
           abort_i, wr_gnt_i,
    input  cmd_ready_o, we_o, addr_x_o, addr_y_o, color_o, busy_o, done_o,
           err_o, aborted_o, pix_cnt_o
  );

endinterface
`default_nettype wire

// File: rtl/vga_fill_addr_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vga_fill_addr_gen : x-fastest raster counter over an inclusive rectangle
// rev 1.0 : initial release
// ----------------------------------------------------------------------------
module vga_fill_addr_gen #(
  parameter int X_WIDTH = 11,
  parameter int Y_WIDTH = 11
) (
  input  wire logic               clk,
  input  wire logic               rst,
  input  wire logic               load,
  input  wire logic [X_WIDTH-1:0] x0,
  input  wire logic [Y_WIDTH-1:0] y0,
  input  wire logic [X_WIDTH-1:0] x1,
  input  wire logic [Y_WIDTH-1:0] y1,
  input  wire logic               step,
  output logic      [X_WIDTH-1:0] x,
  output logic      [Y_WIDTH-1:0] y,
  output logic                    last
);

  logic [X_WIDTH-1:0] x_start;
  logic [X_WIDTH-1:0] x_end;
  logic [Y_WIDTH-1:0] y_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x       <= '0;
      y       <= '0;
      x_start <= '0;
      x_end   <= '0;
      y_end   <= '0;
    end else if (load) begin
      x       <= x0;
      y       <= y0;
      x_start <= x0;
      x_end   <= x1;
      y_end   <= y1;
    end else if (step) begin
      // y stays on the final row after the last pixel; the FSM leaves WRITE there
      if (x == x_end) begin
        x <= x_start;
        if (y != y_end) y <= y + Y_WIDTH'(1);
      end else begin
        x <= x + X_WIDTH'(1);
      end
    end
  end

  assign last = (x == x_end) && (y == y_end);

endmodule
`default_nettype wire

// File: rtl/vga_rect_fill.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vga_rect_fill : clips a rectangle-fill command and issues one write per pixel
// rev 1.0 : initial release
// ----------------------------------------------------------------------------
module vga_rect_fill
  import vga_pkg::*;
#(
  parameter int X_WIDTH     = 11,
  parameter int Y_WIDTH     = 11,
  parameter int COLOR_WIDTH = 2,
  parameter int MAX_H       = VGA_MAX_H,
  parameter int MAX_V       = VGA_MAX_V
) (
  input wire logic        clk_i,
  input wire logic        arst_i,
  vga_rect_fill_if.slave  bus
);

  localparam int                 CNT_W  = X_WIDTH + Y_WIDTH;
  localparam logic [X_WIDTH-1:0] X_LAST = X_WIDTH'(MAX_H - 1);
  localparam logic [Y_WIDTH-1:0] Y_LAST = Y_WIDTH'(MAX_V - 1);

  vga_fill_state_e        state;
  logic                   ready;
  logic                   we;
  logic                   busy;
  logic                   done;
  logic                   err;
  logic                   aborted;
  logic [CNT_W-1:0]       pix_cnt;
  logic [COLOR_WIDTH-1:0] color;

  logic [31:0]            x0_ext;
  logic [31:0]            x1_ext;
  logic [31:0]            y0_ext;
  logic [31:0]            y1_ext;
  logic [X_WIDTH-1:0]     x1_clip;
  logic [Y_WIDTH-1:0]     y1_clip;
  logic                   reject;
  logic                   load;
  logic                   step;
  logic                   last;
  logic [X_WIDTH-1:0]     gen_x;
  logic [Y_WIDTH-1:0]     gen_y;

  // Compare in 32 bits so frame limits wider than the coordinate fields still work
  assign x0_ext  = 32'(bus.cmd_x0_i);
  assign x1_ext  = 32'(bus.cmd_x1_i);
  assign y0_ext  = 32'(bus.cmd_y0_i);
  assign y1_ext  = 32'(bus.cmd_y1_i);
  assign x1_clip = (x1_ext > 32'(MAX_H - 1)) ? X_LAST : bus.cmd_x1_i;
  assign y1_clip = (y1_ext > 32'(MAX_V - 1)) ? Y_LAST : bus.cmd_y1_i;
  assign reject  = (x0_ext >= 32'(MAX_H)) || (y0_ext >= 32'(MAX_V)) ||
                   (bus.cmd_x0_i > x1_clip) || (bus.cmd_y0_i > y1_clip);

  assign load = (state == IDLE) && bus.cmd_valid_i && !reject;
  assign step = (state == WRITE) && bus.wr_gnt_i && !bus.abort_i;

  vga_fill_addr_gen #(
    .X_WIDTH (X_WIDTH),
    .Y_WIDTH (Y_WIDTH)
  ) u_addr_gen (
    .clk  (clk_i),
    .rst  (arst_i),
    .load (load),
    .x0   (bus.cmd_x0_i),
    .y0   (bus.cmd_y0_i),
    .x1   (x1_clip),
    .y1   (y1_clip),
    .step (step),
    .x    (gen_x),
    .y    (gen_y),
    .last (last)
  );

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state   <= IDLE;
      ready   <= 1'b1;
      we      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      aborted <= 1'b0;
      pix_cnt <= '0;
      color   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid_i) begin
            pix_cnt <= '0;
            color   <= bus.cmd_color_i;
            err     <= reject;
            aborted <= 1'b0;
            ready   <= 1'b0;
            busy    <= 1'b1;
            if (reject) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= WRITE;
              we    <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (bus.wr_gnt_i) pix_cnt <= pix_cnt + CNT_W'(1);
          // A grant in the abort cycle still completes that pixel
          if (bus.abort_i || (bus.wr_gnt_i && last)) begin
            state   <= DONE;
            we      <= 1'b0;
            done    <= 1'b1;
            aborted <= bus.abort_i;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
          ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          we    <= 1'b0;
          done  <= 1'b0;
          busy  <= 1'b0;
          ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.cmd_ready_o = ready;
  assign bus.we_o        = we;
  assign bus.addr_x_o    = gen_x;
  assign bus.addr_y_o    = gen_y;
  assign bus.color_o     = color;
  assign bus.busy_o      = busy;
  assign bus.done_o      = done;
  assign bus.err_o       = err;
  assign bus.aborted_o   = aborted;
  assign bus.pix_cnt_o   = pix_cnt;

endmodule
`default_nettype wire

// File: tb/tb_vga_rect_fill.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_vga_rect_fill : directed and random fills against a pixel-list model
// rev 1.0 : initial release
// ----------------------------------------------------------------------------
module tb_vga_rect_fill;
  import vga_pkg::*;

  localparam int XW    = 11;
  localparam int YW    = 11;
  localparam int CW    = 2;
  localparam int MAX_H = 1280;
  localparam int MAX_V = 1024;

  logic  clk = 1'b0;
  logic  arst;
  int    total = 0;
  int    bad   = 0;
  string cur   = "init";

  vga_rect_fill_if #(.X_WIDTH(XW), .Y_WIDTH(YW), .COLOR_WIDTH(CW)) bus ();

  vga_rect_fill #(
    .X_WIDTH     (XW),
    .Y_WIDTH     (YW),
    .COLOR_WIDTH (CW),
    .MAX_H       (MAX_H),
    .MAX_V       (MAX_V)
  ) dut (
    .clk_i  (clk),
    .arst_i (arst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s/%s: got %0d expected %0d at %0t", cur, tag, got, exp, $time);
    end
  endtask

  task automatic check_idle_reset();
    check_val("rst_ready", int'(bus.cmd_ready_o), 1);
    check_val("rst_we", int'(bus.we_o), 0);
    check_val("rst_busy", int'(bus.busy_o), 0);
    check_val("rst_done", int'(bus.done_o), 0);
    check_val("rst_err", int'(bus.err_o), 0);
    check_val("rst_aborted", int'(bus.aborted_o), 0);
    check_val("rst_ax", int'(bus.addr_x_o), 0);
    check_val("rst_ay", int'(bus.addr_y_o), 0);
    check_val("rst_color", int'(bus.color_o), 0);
    check_val("rst_pix", int'(bus.pix_cnt_o), 0);
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  // mode: 0 constant grant, 1 grant every third cycle, 2 random grant.
  task automatic run_cmd(input string name, input int x0, input int x1, input int y0,
                         input int y1, input int col, input int mode,
                         input int abort_at, input int abort_gnt);
    int qx[$];
    int qy[$];
    int xe, ye, n, cyc, exp_n;
    bit rej, ab, g, fin;
    cur = name;
    xe  = (x1 > MAX_H - 1) ? MAX_H - 1 : x1;
    ye  = (y1 > MAX_V - 1) ? MAX_V - 1 : y1;
    rej = (x0 >= MAX_H) || (y0 >= MAX_V) || (x0 > xe) || (y0 > ye);
    if (!rej)
      for (int yy = y0; yy <= ye; yy++)
        for (int xx = x0; xx <= xe; xx++) begin
          qx.push_back(xx);
          qy.push_back(yy);
        end
    ab = 1'b0;

    check_val("ready", int'(bus.cmd_ready_o), 1);
    bus.cmd_x0_i    = XW'(x0);
    bus.cmd_x1_i    = XW'(x1);
    bus.cmd_y0_i    = YW'(y0);
    bus.cmd_y1_i    = YW'(y1);
    bus.cmd_color_i = CW'(col);
    bus.cmd_valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;

    if (rej) begin
      check_val("rej_done", int'(bus.done_o), 1);
      check_val("rej_err", int'(bus.err_o), 1);
      check_val("rej_we", int'(bus.we_o), 0);
      check_val("rej_pix", int'(bus.pix_cnt_o), 0);
      check_val("rej_aborted", int'(bus.aborted_o), 0);
    end else begin
      n   = 0;
      cyc = 0;
      fin = 1'b0;
      while (!fin) begin
        check_val("we", int'(bus.we_o), 1);
        check_val("busy", int'(bus.busy_o), 1);
        check_val("ready_busy", int'(bus.cmd_ready_o), 0);
        check_val("done_early", int'(bus.done_o), 0);
        check_val("ax", int'(bus.addr_x_o), qx[n]);
        check_val("ay", int'(bus.addr_y_o), qy[n]);
        check_val("color", int'(bus.color_o), col);
        check_val("pix_run", int'(bus.pix_cnt_o), n);
        ab = (abort_at >= 0) && (n == abort_at);
        if (ab) g = abort_gnt[0];
        else if (mode == 0) g = 1'b1;
        else if (mode == 1) g = (cyc % 3 == 2);
        else g = $urandom_range(0, 1) == 1;
        bus.wr_gnt_i = g;
        bus.abort_i  = ab;
        @(posedge clk);
        if (g) n++;
        if (ab || n == qx.size()) fin = 1'b1;
        cyc++;
        if (cyc > 20000) begin
          check_val("timeout", cyc, 0);
          fin = 1'b1;
        end
        @(negedge clk);
      end
      bus.wr_gnt_i = 1'b0;
      bus.abort_i  = 1'b0;
      exp_n = ab ? abort_at + abort_gnt : qx.size();
      check_val("done", int'(bus.done_o), 1);
      check_val("we_off", int'(bus.we_o), 0);
      check_val("err", int'(bus.err_o), 0);
      check_val("aborted", int'(bus.aborted_o), int'(ab));
      check_val("pix_final", int'(bus.pix_cnt_o), exp_n);
    end

    @(negedge clk);
    check_val("done_pulse", int'(bus.done_o), 0);
    check_val("ready_after", int'(bus.cmd_ready_o), 1);
    check_val("busy_after", int'(bus.busy_o), 0);
    check_val("err_hold", int'(bus.err_o), int'(rej));
    check_val("aborted_hold", int'(bus.aborted_o), int'(ab));
  endtask

  initial begin
    int x0, x1, y0, y1, mode, ab_at, ab_g, area;
    arst            = 1'b1;
    bus.cmd_valid_i = 1'b0;
    bus.cmd_x0_i    = '0;
    bus.cmd_x1_i    = '0;
    bus.cmd_y0_i    = '0;
    bus.cmd_y1_i    = '0;
    bus.cmd_color_i = '0;
    bus.abort_i     = 1'b0;
    bus.wr_gnt_i    = 1'b0;
    repeat (2) @(negedge clk);
    cur = "reset";
    check_idle_reset();
    arst = 1'b0;
    @(negedge clk);

    run_cmd("basic", 2, 4, 3, 4, int'(BLUE), 0, -1, 0);
    run_cmd("gnt_1of3", 2, 4, 3, 4, int'(BLUE), 1, -1, 0);
    run_cmd("clip", 1270, 2000, 1020, 2000, int'(GREEN), 0, -1, 0);
    run_cmd("rej_x0gtx1", 5, 4, 0, 3, int'(WHITE), 0, -1, 0);
    run_cmd("rej_x0max", 1280, 1290, 0, 3, int'(WHITE), 0, -1, 0);
    run_cmd("rej_y0max", 0, 3, 1024, 1030, int'(WHITE), 0, -1, 0);
    run_cmd("abort_nogrant", 0, 3, 0, 3, int'(WHITE), 0, 3, 0);
    run_cmd("abort_grant", 0, 3, 0, 3, int'(BLACK), 0, 3, 1);

    // Asynchronous reset in the middle of a fill
    cur = "mid_reset";
    bus.cmd_x0_i    = XW'(0);
    bus.cmd_x1_i    = XW'(7);
    bus.cmd_y0_i    = YW'(0);
    bus.cmd_y1_i    = YW'(7);
    bus.cmd_color_i = CW'(3);
    bus.cmd_valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    bus.wr_gnt_i    = 1'b1;
    repeat (5) @(negedge clk);
    check_val("pre_rst_we", int'(bus.we_o), 1);
    #2 arst = 1'b1;
    #1 check_idle_reset();
    @(negedge clk);
    arst         = 1'b0;
    bus.wr_gnt_i = 1'b0;
    run_cmd("post_reset", 10, 12, 20, 21, int'(GREEN), 0, -1, 0);

    for (int i = 0; i < 25; i++) begin
      x0 = $urandom_range(0, 1285);
      x1 = x0 + $urandom_range(0, 9) - 1;
      if (x1 < 0) x1 = 0;
      y0 = $urandom_range(0, 1027);
      y1 = y0 + $urandom_range(0, 6) - 1;
      if (y1 < 0) y1 = 0;
      if ($urandom_range(0, 7) == 0) x1 = x0 + 700;
      mode  = $urandom_range(0, 2);
      ab_at = -1;
      ab_g  = 0;
      area  = ((x1 > MAX_H - 1 ? MAX_H - 1 : x1) - x0 + 1) *
              ((y1 > MAX_V - 1 ? MAX_V - 1 : y1) - y0 + 1);
      if (area > 0 && $urandom_range(0, 3) == 0) begin
        ab_at = $urandom_range(0, area - 1);
        ab_g  = $urandom_range(0, 1);
      end
      run_cmd($sformatf("rand%0d", i), x0, x1, y0, y1, $urandom_range(0, 3),
              mode, ab_at, ab_g);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
